reg_op_rr_scheduler: RTL
========================

Name: reg_op_rr_scheduler

Overview:
- Round-robin scheduler that shares one 4-function register (hold/clear/complement/load, selected by a 2-bit S with parallel input I) between N requesters.
- Each requester posts an operation plus load data. The scheduler grants one requester at a time and drives S/I for exactly one clock.
- After the register updates, it returns the new register value to the granted requester.
- Sits between client logic and the shared register; the register stays a separate instance.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, register/data width.
- IDW, 2, requester index width; must equal ceil(log2(N)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; held until granted.
- req_op  in  2*N  op for requester k in bits [2k+1:2k].
- req_data  in  N*W  load data for requester k in bits [kW+W-1:kW].
- gnt  out  N  one-hot acceptance pulse, one cycle.
- reg_s  out  2  S select to shared register.
- reg_i  out  W  I parallel data to shared register.
- reg_a  in  W  current register output A.
- rsp_valid  out  1  response pulse, one cycle.
- rsp_id  out  IDW  index of requester being answered.
- rsp_data  out  W  register value after the operation.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Op encoding: 00 hold, 01 clear, 10 complement, 11 load I.
- Reset (rst high at clk edge): state=IDLE; gnt=0, reg_s=00, reg_i=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0; round-robin pointer=0. reg_s=00 keeps the shared register undisturbed.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer, wrapping at N-1 -> 0.
  - gnt is combinational, one-hot, high this cycle only.
  - At the edge: latch op, data and id; pointer := id+1 mod N; go to ISSUE.
  - If req is all zero, stay in IDLE with gnt=0.
- ISSUE:
  - reg_s=latched op, reg_i=latched data, for exactly one cycle.
  - The register updates at the ending edge; go to CAPTURE.
- CAPTURE:
  - reg_s=00.
  - At the edge: rsp_data := reg_a, rsp_id := latched id, rsp_valid := 1; go to IDLE.
  - rsp_valid is therefore seen high during the following IDLE cycle.
- Outside ISSUE, reg_s is always 00 and reg_i holds its last value.
- Latency: request accepted at edge t; register written at t+1; rsp_valid high during cycle t+2..t+3.
- Throughput: one op per 3 cycles. A new grant may occur in the same IDLE cycle in which rsp_valid is high.
- Requester rules:
  - Requester must drop req on the cycle after its gnt, or it is treated as a new request.
  - req_op and req_data must be stable while req is high.
- Fairness: a requester that keeps req high is granted within N grants.
- Reset mid-operation (ISSUE or CAPTURE): abort. No rsp_valid. If already in ISSUE, the register may have been written at that same edge; reg_s returns to 00 at the reset edge.

Optional Feature:
- Macro: REG_OP_SCHED_HOLD_BYPASS_EN.
- Defined:
  - A granted op 00 skips ISSUE; IDLE goes directly to CAPTURE, giving 2-cycle service.
  - The response carries the current reg_a.
- Undefined: hold ops take the full 3-state path, with reg_s=00 driven during ISSUE.

Decomposition:
- Shared package:
  - Op constants OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_COMP=2'b10, OP_LOAD=2'b11.
  - State enum IDLE/ISSUE/CAPTURE.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N] and ptr[IDW]; outputs one-hot gnt and binary id.
  - Purely combinational; the pointer register lives in the parent.

Test Plan (N=4, W=4, behavioural shared register, reset value 0000):
- Reset, then req=0001 with op 11, data 1010 -> gnt=0001 in cycle 0; reg_s=11, reg_i=1010 in cycle 1; rsp_valid with rsp_id=0, rsp_data=1010 two cycles after the grant edge.
- All four requesters assert together (ops 10,01,11 data 0110,10 from A=1010) -> grants in order 0,1,2,3. rsp_data sequence: 0101, 0000, 0110, 1001.
- Requester 2 holds req continuously while 0 and 3 request -> grant order 0,2,3,0,2,… with no requester skipped.
- Assert rst during ISSUE of a load 1111 -> no rsp_valid; reg_s=00 after the reset edge; busy=0; the next grant goes to requester 0 first.
- Op 00 with A=0110 -> rsp_data=0110; 3-cycle service without the macro, 2-cycle with REG_OP_SCHED_HOLD_BYPASS_EN.
- Idle bench with no req -> reg_s stays 00, gnt=0, busy=0 for 20 cycles.

Source files
------------

// File: rtl/reg_op_rr_scheduler_pkg.sv
// Shared definitions for the round-robin register-op scheduler.
//   - Op codes driven onto the shared register's S select.
//   - Scheduler FSM state encoding.
package reg_op_rr_scheduler_pkg;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_COMP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StIssue   = 2'b01,
    StCapture = 2'b10
  } state_e;

endpackage

// File: rtl/reg_op_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter (rr_arbiter).
// Picks the first set request searching upward from ptr_i, wrapping N-1 -> 0.
// Ports:
//   req_i   [N]   request vector
//   ptr_i   [IDW] search start index (always < N)
//   gnt_o   [N]   one-hot grant, zero when no request
//   id_o    [IDW] binary index of the granted requester
//   valid_o       any request present
module reg_op_rr_scheduler_rr_arbiter
  import reg_op_rr_scheduler_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           valid_o
);

  localparam logic [IDW:0] NumReq = (IDW + 1)'(N);

  logic [IDW:0]   idx_wide;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt_o    = '0;
    id_o     = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr_i + i stays below 2N, so a single subtract performs the wrap.
      idx_wide = {1'b0, ptr_i} + (IDW + 1)'(i);
      if (idx_wide >= NumReq) begin
        idx_wide = idx_wide - NumReq;
      end
      idx = idx_wide[IDW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/reg_op_rr_scheduler.sv
// Round-robin scheduler sharing one hold/clear/complement/load register among N requesters.
// A grant latches the requester's op/data, drives S/I for one cycle, then returns the updated
// register value as a one-cycle response.
// Optional feature macro: REG_OP_SCHED_HOLD_BYPASS_EN -- hold ops skip the ISSUE state.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i [N]          per-requester request, held until granted
//   req_op_i [2N]      op of requester k at [2k+1:2k]
//   req_data_i [NW]    load data of requester k at [kW+W-1:kW]
//   gnt_o [N]          one-hot acceptance pulse
//   reg_s_o, reg_i_o   S select / I data to the shared register
//   reg_a_i            shared register output A
//   rsp_valid_o, rsp_id_o, rsp_data_o   response pulse, requester index, register value
//   busy_o             FSM not idle
module reg_op_rr_scheduler
  import reg_op_rr_scheduler_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic [2*N-1:0]   req_op_i,
  input  logic [N*W-1:0]   req_data_i,
  output logic [N-1:0]     gnt_o,
  output logic [1:0]       reg_s_o,
  output logic [W-1:0]     reg_i_o,
  input  logic [W-1:0]     reg_a_i,
  output logic             rsp_valid_o,
  output logic [IDW-1:0]   rsp_id_o,
  output logic [W-1:0]     rsp_data_o,
  output logic             busy_o
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   data_q, data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;

  logic [N-1:0]   arb_gnt;
  logic [IDW-1:0] arb_id;
  logic           arb_valid;
  logic [1:0]     sel_op;
  logic [W-1:0]   sel_data;
  logic           take;

  reg_op_rr_scheduler_rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

  // Select the winner's op and data from the flattened request buses.
  always_comb begin
    sel_op   = OP_HOLD;
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (arb_gnt[k]) begin
        sel_op   = req_op_i[2*k +: 2];
        sel_data = req_data_i[W*k +: W];
      end
    end
  end

  assign take = (state_q == StIdle) && arb_valid;

  // State register (also holds the datapath registers).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= OP_HOLD;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
`ifdef REG_OP_SCHED_HOLD_BYPASS_EN
          state_d = (sel_op == OP_HOLD) ? StCapture : StIssue;
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (take) begin
      id_d  = arb_id;
      ptr_d = (arb_id == IDW'(N - 1)) ? '0 : arb_id + 1'b1;
      // Op/data only change when they will be issued, so reg_i keeps its last driven value.
      if (state_d == StIssue) begin
        op_d   = sel_op;
        data_d = sel_data;
      end
    end
    if (state_q == StCapture) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = id_q;
      rsp_data_d  = reg_a_i;
    end
  end

  // Outputs.
  always_comb begin
    gnt_o       = (state_q == StIdle && !rst_i) ? arb_gnt : '0;
    reg_s_o     = (state_q == StIssue) ? op_q : OP_HOLD;
    reg_i_o     = data_q;
    busy_o      = (state_q != StIdle);
    rsp_valid_o = rsp_valid_q;
    rsp_id_o    = rsp_id_q;
    rsp_data_o  = rsp_data_q;
  end

endmodule
